// File: rtl/ttd_pkg.sv
// Shared definitions for the TTD temperature path.
//   TTD_DATA_W  : converter code width, shared with the converter top
//   ttd_state_e : sample-filter FSM states
package ttd_pkg;

    localparam int TTD_DATA_W = 9;

    // Prefixed so the state names cannot collide with the SETTLE parameter.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2
    } ttd_state_e;

endpackage

// File: rtl/ttd_sample_filter_if.sv
// Valid/ready bus carrying averaged converter codes.
//   avg_data  : averaged code
//   avg_valid : avg_data holds an unconsumed average
//   avg_ready : sink accepts avg_data when avg_valid && avg_ready
// master = filter (producer), slave = sink.
interface ttd_sample_filter_if
    import ttd_pkg::*;
#(
    parameter int DATA_W = TTD_DATA_W
);
    logic [DATA_W-1:0] avg_data;
    logic              avg_valid;
    logic              avg_ready;

    modport master (output avg_data, output avg_valid, input  avg_ready);
    modport slave  (input  avg_data, input  avg_valid, output avg_ready);
endinterface

// File: rtl/ttd_sample_filter_sync_rise_det.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse.
//   clk, rst : clock, synchronous active-high reset
//   async_i  : asynchronous input
//   rise_o   : one-cycle pulse on a synchronised 0->1 transition
// Everything resets to 1 so an input that is already high after reset
// does not produce a false edge.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;
endmodule

// File: rtl/ttd_sample_filter.sv
// Sample filter for the time-to-digital temperature converter.
// Detects end of conversion on the capacitor-reset strobe, samples the
// compensated code after a settle delay, boxcar-averages 2**LOG2_AVG
// samples, publishes each average on a valid/ready bus and drives an
// over-temperature alarm with hysteresis.
//   clk, rst      : clock, synchronous active-high reset
//   conv_strobe_i : converter strobe, asynchronous to clk
//   data_in_i     : compensated code, stable after strobe rise
//   alarm_hi_i    : alarm set threshold
//   alarm_lo_i    : alarm clear threshold
//   overrun_clr_i : one-cycle pulse clearing overrun_o
//   avg_if        : averaged-code bus (master)
//   alarm_o       : over-temperature flag
//   overrun_o     : sticky, a completed average was dropped
module ttd_sample_filter
    import ttd_pkg::*;
#(
    parameter int DATA_W   = TTD_DATA_W,
    parameter int LOG2_AVG = 3,
    parameter int SETTLE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_strobe_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [DATA_W-1:0] alarm_hi_i,
    input  logic [DATA_W-1:0] alarm_lo_i,
    input  logic              overrun_clr_i,
    ttd_sample_filter_if.master avg_if,
    output logic              alarm_o,
    output logic              overrun_o
);
    localparam int AW = DATA_W + LOG2_AVG;           // sum of a full window fits
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    ttd_state_e        state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [LOG2_AVG-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic              avg_valid_q, avg_valid_d;
    logic              alarm_q, alarm_d;
    logic              overrun_q, overrun_d;

    logic              edge_w;
    logic [AW-1:0]     sum_w;
    logic [DATA_W-1:0] avg_w;
    logic              win_done_w;

    sync_rise_det u_strobe_det (
        .clk     (clk),
        .rst     (rst),
        .async_i (conv_strobe_i),
        .rise_o  (edge_w)
    );

    assign sum_w      = acc_q + AW'(data_in_i);
    assign avg_w      = DATA_W'(sum_w >> LOG2_AVG);
    // The ACCUM whose count increment wraps closes the window.
    assign win_done_w = (state_q == S_ACCUM) && (cnt_q == {LOG2_AVG{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_data_q  <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_data_q  <= avg_data_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_data_d  = avg_data_q;
        avg_valid_d = avg_valid_q;
        alarm_d     = alarm_q;
        overrun_d   = overrun_q;

        // Edges outside IDLE are ignored: glitches during settle do not resample.
        unique case (state_q)
            S_IDLE: begin
                if (edge_w) begin
                    state_d  = S_SETTLE;
                    settle_d = SW'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d  = S_ACCUM;
                else                settle_d = settle_q - SW'(1);
            end
            S_ACCUM: begin
                cnt_d   = cnt_q + LOG2_AVG'(1);
                acc_d   = win_done_w ? '0 : sum_w;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (avg_valid_q && avg_if.avg_ready) avg_valid_d = 1'b0;
        if (overrun_clr_i)                   overrun_d   = 1'b0;

        // Assigned after the clear so a same-cycle drop keeps overrun set.
        if (win_done_w) begin
            if (!avg_valid_q || avg_if.avg_ready) begin
                avg_data_d  = avg_w;
                avg_valid_d = 1'b1;
                if (avg_w >= alarm_hi_i)      alarm_d = 1'b1;
                else if (avg_w <= alarm_lo_i) alarm_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign avg_if.avg_data  = avg_data_q;
    assign avg_if.avg_valid = avg_valid_q;
    assign alarm_o          = alarm_q;
    assign overrun_o        = overrun_q;
endmodule

// File: tb/tb_ttd_sample_filter.sv
module tb_ttd_sample_filter;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b1;
    logic [8:0] data = '0;
    logic [8:0] hi = 9'd511;
    logic [8:0] lo = 9'd0;
    logic       oclr = 1'b0;
    logic       alarm, overrun;

    ttd_sample_filter_if u_if ();

    always #5 clk = ~clk;

    ttd_sample_filter dut (
        .clk           (clk),
        .rst           (rst),
        .conv_strobe_i (strobe),
        .data_in_i     (data),
        .alarm_hi_i    (hi),
        .alarm_lo_i    (lo),
        .overrun_clr_i (oclr),
        .avg_if        (u_if),
        .alarm_o       (alarm),
        .overrun_o     (overrun)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: window of samples, published value, pending flag.
    int win[$];
    int exp_q[$];
    int exp_alarm_q[$];
    int m_data = 0;
    bit m_valid = 0, m_alarm = 0, m_ovr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_sample(input int d);
        int sum, avg;
        win.push_back(d);
        if (win.size() == N) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            avg = sum / N;
            win.delete();
            if (!m_valid || u_if.avg_ready) begin
                m_data = avg;
                if (avg >= int'(hi))      m_alarm = 1;
                else if (avg <= int'(lo)) m_alarm = 0;
                exp_q.push_back(avg);
                exp_alarm_q.push_back(int'(m_alarm));
                m_valid = !u_if.avg_ready;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // Every accepted average must be the next one the model published.
    always @(negedge clk) begin
        if (!rst && u_if.avg_valid && u_if.avg_ready) begin
            if (exp_q.size() == 0) chk("unexpected_avg", int'(u_if.avg_data), -1);
            else begin
                chk("avg_data", int'(u_if.avg_data), exp_q.pop_front());
                chk("alarm_at_publish", int'(alarm), exp_alarm_q.pop_front());
            end
        end
    end

    task automatic checkpoint(input string tag);
        chk({tag, "_valid"},   int'(u_if.avg_valid), int'(m_valid));
        chk({tag, "_data"},    int'(u_if.avg_data),  m_data);
        chk({tag, "_alarm"},   int'(alarm),          int'(m_alarm));
        chk({tag, "_overrun"}, int'(overrun),        int'(m_ovr));
    endtask

    task automatic do_sample(input int d);
        @(posedge clk); #1;
        data = 9'(d);
        model_sample(d);
        strobe = 1'b1;
        repeat (10) @(posedge clk);
        #1 strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1 checkpoint("sample");
    endtask

    // Strobe drops for one cycle right after rising: the second edge lands
    // while the filter is settling and must not cause a second sample.
    task automatic do_glitch_sample(input int d);
        @(posedge clk); #1;
        data = 9'(d);
        model_sample(d);
        strobe = 1'b1;
        @(posedge clk); #1 strobe = 1'b0;
        @(posedge clk); #1 strobe = 1'b1;
        repeat (10) @(posedge clk);
        #1 strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1 checkpoint("glitch");
    endtask

    task automatic window(input int d);
        for (int i = 0; i < N; i++) do_sample(d);
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk); #1;
        u_if.avg_ready = v;
        if (v) m_valid = 0;
        repeat (2) @(posedge clk);
        #1 checkpoint("ready");
    endtask

    task automatic clr_ovr();
        @(posedge clk); #1 oclr = 1'b1;
        @(posedge clk); #1 oclr = 1'b0;
        m_ovr = 0;
        checkpoint("clr");
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        win.delete(); exp_q.delete(); exp_alarm_q.delete();
        m_data = 0; m_valid = 0; m_alarm = 0; m_ovr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkpoint("reset");
    endtask

    initial begin
        u_if.avg_ready = 1'b1;
        // Strobe high through reset, then released: no false edge.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avg_data",  int'(u_if.avg_data),  0);
        chk("rst_avg_valid", int'(u_if.avg_valid), 0);
        chk("rst_alarm",     int'(alarm),          0);
        chk("rst_overrun",   int'(overrun),        0);
        rst = 1'b0;
        data = 9'd500;
        repeat (5) @(posedge clk);
        #1 strobe = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < N; i++) do_sample(10 * (i + 1));
        chk("lit_avg45", int'(u_if.avg_data), 45);

        window(100);
        chk("lit_avg100", int'(u_if.avg_data), 100);
        chk("lit_ovr0",   int'(overrun), 0);

        for (int i = 0; i < N; i++) do_sample(i);
        chk("lit_avg3", int'(u_if.avg_data), 3);

        window(511);
        chk("lit_avg511",   int'(u_if.avg_data), 511);
        chk("lit_alarm511", int'(alarm), 1);

        // Hysteresis.
        hi = 9'd300; lo = 9'd280;
        window(310); chk("lit_alarm310", int'(alarm), 1);
        window(290); chk("lit_alarm290", int'(alarm), 1);
        window(280); chk("lit_alarm280", int'(alarm), 0);
        window(295); chk("lit_alarm295", int'(alarm), 0);

        // Back-pressure and overrun.
        set_ready(1'b0);
        window(50);
        chk("lit_bp_valid", int'(u_if.avg_valid), 1);
        chk("lit_bp_data",  int'(u_if.avg_data), 50);
        window(60);
        chk("lit_drop_data", int'(u_if.avg_data), 50);
        chk("lit_drop_ovr",  int'(overrun), 1);
        set_ready(1'b1);
        chk("lit_drain_valid", int'(u_if.avg_valid), 0);
        chk("lit_drain_ovr",   int'(overrun), 1);
        clr_ovr();
        chk("lit_clr_ovr", int'(overrun), 0);

        // Reset mid-window discards the partial sum.
        for (int i = 0; i < 5; i++) do_sample(400);
        do_reset();
        window(40);
        chk("lit_avg40", int'(u_if.avg_data), 40);

        // Glitchy strobe.
        for (int i = 0; i < N; i++) do_glitch_sample(30 * i + 7);
        chk("lit_glitch_avg", int'(u_if.avg_data), 112);

        // Randomised windows with random back-pressure and thresholds.
        for (int w = 0; w < 20; w++) begin
            hi = 9'($urandom_range(150, 511));
            lo = 9'($urandom_range(0, 300));
            set_ready(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) clr_ovr();
            for (int i = 0; i < N; i++) do_sample(int'($urandom_range(0, 511)));
        end
        set_ready(1'b1);
        clr_ovr();
        repeat (4) @(posedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
